// File: rtl/eq_ctrl_pkg.sv
// Shared definitions for the EQ gain loader slice.
//   eq_state_e      loader FSM states
//   EQ_MAX_FILTERS  upper bound on gain entries (sizes the banks and the 4-bit index)
//   EQ_GAIN_W       width of one signed gain value
package eq_ctrl_pkg;

  localparam int unsigned EQ_MAX_FILTERS = 16;
  localparam int unsigned EQ_GAIN_W      = 16;

  typedef enum logic [2:0] {
    StIdle,
    StPend,
    StRst,
    StGap,
    StWr,
    StWgap,
    StDone
  } eq_state_e;

endpackage

// File: rtl/eq_gain_loader_if.sv
// Bus bundle between the CPU/audio side and the EQ gain loader.
//   master: drives CPU strobes, frame strobes and EQ status; observes loader outputs
//   slave : the loader itself
interface eq_gain_loader_if;
  import eq_ctrl_pkg::*;

  logic                 cpu_wr;
  logic [3:0]           cpu_addr;
  logic [EQ_GAIN_W-1:0] cpu_data;
  logic                 commit;
  logic                 clr_status;
  logic                 r_data_en;
  logic                 eq_valid;
  logic                 wr_addr_zero;
  logic                 eq_wr;
  logic                 eq_wr_rst;
  logic [7:0]           eq_gain_lsb;
  logic [7:0]           eq_gain_msb;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 tear;

  modport master (
    output cpu_wr, cpu_addr, cpu_data, commit, clr_status, r_data_en, eq_valid, wr_addr_zero,
    input  eq_wr, eq_wr_rst, eq_gain_lsb, eq_gain_msb, busy, done, err, tear
  );

  modport slave (
    input  cpu_wr, cpu_addr, cpu_data, commit, clr_status, r_data_en, eq_valid, wr_addr_zero,
    output eq_wr, eq_wr_rst, eq_gain_lsb, eq_gain_msb, busy, done, err, tear
  );

endinterface

// File: rtl/eq_gain_bank.sv
// Shadow and active gain banks.
//   clk, reset      clock, synchronous active-high reset (clears both banks)
//   cpu_wr/addr/data  shadow write port; addresses >= num_of_filters are dropped
//   snap            copy shadow -> active on this edge (same-cycle cpu_wr lands in shadow only)
//   rd_idx, rd_data combinational read of the active bank
module eq_gain_bank
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned num_of_filters = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_wr,
  input  logic [3:0]           cpu_addr,
  input  logic [EQ_GAIN_W-1:0] cpu_data,
  input  logic                 snap,
  input  logic [3:0]           rd_idx,
  output logic [EQ_GAIN_W-1:0] rd_data
);

  // Banks span the full 4-bit index; entries at or above num_of_filters are never written
  // and stay zero.
  logic [EQ_GAIN_W-1:0] shadow_q [EQ_MAX_FILTERS];
  logic [EQ_GAIN_W-1:0] active_q [EQ_MAX_FILTERS];
  logic                 wr_hit;

  assign wr_hit = cpu_wr && ({28'd0, cpu_addr} < num_of_filters);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < EQ_MAX_FILTERS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (wr_hit) shadow_q[cpu_addr] <= cpu_data;
      // Reads the pre-edge shadow, so a simultaneous cpu_wr is excluded from the snapshot.
      if (snap) begin
        for (int unsigned k = 0; k < EQ_MAX_FILTERS; k++) begin
          active_q[k] <= shadow_q[k];
        end
      end
    end
  end

  assign rd_data = active_q[rd_idx];

endmodule

// File: rtl/eq_gain_loader.sv
// Transfers a committed bank of EQ gains into the EQ gain RAM.
//   clk, reset  clock, synchronous active-high reset
//   bus         eq_gain_loader_if.slave: CPU shadow writes/commit/clr_status, audio frame
//               strobes (r_data_en, eq_valid), EQ status (wr_addr_zero) and the EQ write
//               side (eq_wr, eq_wr_rst, gain bytes) plus busy/done/err/tear status.
// A load waits in PEND for the frame window, pulses eq_wr_rst, then issues one eq_wr every
// other cycle so the EQ has a cycle to advance its write address.
module eq_gain_loader
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned num_of_filters = 4
) (
  input  logic              clk,
  input  logic              reset,
  eq_gain_loader_if.slave   bus
);

  localparam logic [3:0] LastIdx = 4'(num_of_filters - 1);

  eq_state_e            state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [EQ_GAIN_W-1:0] gain_q, gain_d;
  logic [EQ_GAIN_W-1:0] rd_data;
  logic                 snap;
  logic                 pending_q, pending_d;
  logic                 win_open_q, win_open_d;
  logic                 err_q, err_d;
  logic                 tear_q, tear_d;
  logic                 err_set, tear_set, loading;

  eq_gain_bank #(
    .num_of_filters(num_of_filters)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .cpu_wr  (bus.cpu_wr),
    .cpu_addr(bus.cpu_addr),
    .cpu_data(bus.cpu_data),
    .snap    (snap),
    .rd_idx  (idx_d),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gain_d    = gain_q;
    snap      = 1'b0;
    pending_d = pending_q;

    unique case (state_q)
      StIdle: begin
        if (bus.commit) begin
          snap    = 1'b1;
          state_d = StPend;
        end
      end
      StPend: begin
        if (win_open_q && !bus.r_data_en) state_d = StRst;
      end
      StRst:  state_d = StGap;
      StGap: begin
        idx_d   = '0;
        gain_d  = rd_data;
        state_d = StWr;
      end
      StWr:   state_d = StWgap;
      StWgap: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          gain_d  = rd_data;
          state_d = StWr;
        end
      end
      StDone: begin
        // A commit arriving in DONE itself is folded in rather than lost.
        if (pending_q || bus.commit) begin
          snap      = 1'b1;
          pending_d = 1'b0;
          state_d   = StPend;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.commit && (state_q != StIdle) && (state_q != StDone)) pending_d = 1'b1;
  end

  // Frame window: closed by a frame start, reopened by frame completion; close wins.
  always_comb begin
    win_open_d = win_open_q;
    if (bus.r_data_en)     win_open_d = 1'b0;
    else if (bus.eq_valid) win_open_d = 1'b1;
  end

  assign loading  = (state_q == StRst) || (state_q == StGap) ||
                    (state_q == StWr)  || (state_q == StWgap);
  assign err_set  = (state_q == StGap) && !bus.wr_addr_zero;
  assign tear_set = loading && bus.r_data_en;

  always_comb begin
    err_d  = err_q;
    tear_d = tear_q;
    if (bus.clr_status) begin
      err_d  = 1'b0;
      tear_d = 1'b0;
    end
    if (err_set)  err_d  = 1'b1;
    if (tear_set) tear_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      gain_q     <= '0;
      pending_q  <= 1'b0;
      win_open_q <= 1'b1;
      err_q      <= 1'b0;
      tear_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gain_q     <= gain_d;
      pending_q  <= pending_d;
      win_open_q <= win_open_d;
      err_q      <= err_d;
      tear_q     <= tear_d;
    end
  end

  assign bus.eq_wr       = (state_q == StWr);
  assign bus.eq_wr_rst   = (state_q == StRst);
  assign bus.done        = (state_q == StDone);
  assign bus.busy        = (state_q != StIdle);
  assign bus.eq_gain_lsb = gain_q[7:0];
  assign bus.eq_gain_msb = gain_q[EQ_GAIN_W-1:8];
  assign bus.err         = err_q;
  assign bus.tear        = tear_q;

endmodule

// File: tb/tb_eq_gain_loader.sv
// Directed bench for eq_gain_loader (num_of_filters = 4). Inputs change 1ns after each
// rising edge; outputs are sampled there and eq_wr/eq_wr_rst/done events are logged with
// the cycle number so timing can be compared against hand-computed offsets.
module tb_eq_gain_loader;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  int          wr_cyc   [$];
  logic [15:0] wr_val   [$];
  int          rst_cyc  [$];
  int          done_cyc [$];

  eq_gain_loader_if bus();

  eq_gain_loader #(
    .num_of_filters(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.eq_wr === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_val.push_back({bus.eq_gain_msb, bus.eq_gain_lsb});
    end
    if (bus.eq_wr_rst === 1'b1) rst_cyc.push_back(cyc);
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_val.delete();
    rst_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic cpu_write(input logic [3:0] addr, input logic [15:0] data);
    bus.cpu_wr   = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_data = data;
    tick();
    bus.cpu_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  // Checks one four-write load starting with eq_wr at cycle base (entries in vals).
  task automatic check_load(input string tag, input int first, input int base,
                            input logic [15:0] v0, input logic [15:0] v1,
                            input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] vals [4];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int k = 0; k < 4; k++) begin
      int j = first + k;
      check($sformatf("%s_wr%0d_cyc", tag, k), (j < wr_cyc.size()) ? wr_cyc[j] : -1,
            base + 2 * k);
      check($sformatf("%s_wr%0d_val", tag, k), (j < wr_val.size()) ? 32'(wr_val[j]) : -1,
            32'(vals[k]));
    end
  endtask

  int t;
  int v;

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    reset = 1'b1;
    bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.commit = 1'b0; bus.clr_status = 1'b0;
    bus.r_data_en = 1'b0; bus.eq_valid = 1'b0; bus.wr_addr_zero = 1'b1;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_outs", {bus.eq_wr, bus.eq_wr_rst, bus.done, bus.err, bus.tear}, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gain", {bus.eq_gain_msb, bus.eq_gain_lsb}, 32'd0);
    clear_log();

    // Basic load
    cpu_write(4'd0, 16'h1000);
    cpu_write(4'd1, 16'h2000);
    cpu_write(4'd2, 16'h3000);
    cpu_write(4'd3, 16'h4000);
    clear_log();
    bus.commit = 1'b1; t = cyc; tick(); bus.commit = 1'b0;
    wait_idle("basic_idle");
    check("basic_nwr", wr_cyc.size(), 32'd4);
    check("basic_rst", (rst_cyc.size() > 0) ? rst_cyc[0] : -1, t + 2);
    check_load("basic", 0, t + 4, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    check("basic_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 12);
    check("basic_err", 32'(bus.err), 32'd0);
    check("basic_hold", {bus.eq_gain_msb, bus.eq_gain_lsb}, 32'h4000);

    // Window wait: frame start closes the window, load holds until eq_valid reopens it
    clear_log();
    bus.r_data_en = 1'b1; tick(); bus.r_data_en = 1'b0;
    bus.commit = 1'b1; t = cyc; tick(); bus.commit = 1'b0;
    repeat (19) tick();
    v = cyc;
    check("win_no_early", wr_cyc.size() + rst_cyc.size(), 32'd0);
    bus.eq_valid = 1'b1; tick(); bus.eq_valid = 1'b0;
    wait_idle("win_idle");
    check("win_nrst", rst_cyc.size(), 32'd1);
    check("win_rst", (rst_cyc.size() > 0) ? rst_cyc[0] : -1, v + 2);
    check_load("win", 0, v + 4, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    check("win_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, v + 12);
    check("win_tear_idle", 32'(bus.tear), 32'd0);

    // Pending commit: two commits mid-load collapse into one reload carrying 0x7FFF
    clear_log();
    bus.commit = 1'b1; t = cyc; tick(); bus.commit = 1'b0;
    repeat (3) tick();
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    cpu_write(4'd2, 16'h7FFF);
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    wait_idle("pend_idle");
    check("pend_nwr", wr_cyc.size(), 32'd8);
    check("pend_ndone", done_cyc.size(), 32'd2);
    check_load("pend1", 0, t + 4, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    check_load("pend2", 4, t + 16, 16'h1000, 16'h2000, 16'h7FFF, 16'h4000);
    check("pend_done2", (done_cyc.size() > 1) ? done_cyc[1] : -1, t + 24);

    // Status flags
    clear_log();
    bus.wr_addr_zero = 1'b0;
    bus.commit = 1'b1; t = cyc; tick(); bus.commit = 1'b0;
    tick(); tick();
    check("err_in_gap", 32'(bus.err), 32'd0);
    tick();
    check("err_set", 32'(bus.err), 32'd1);
    check("err_wr_state", 32'(bus.eq_wr), 32'd1);
    bus.wr_addr_zero = 1'b1;
    bus.r_data_en = 1'b1; tick(); bus.r_data_en = 1'b0;
    check("tear_set", 32'(bus.tear), 32'd1);
    wait_idle("flag_idle");
    check("tear_load_cont", wr_cyc.size(), 32'd4);
    check("flags_sticky", {bus.err, bus.tear}, 32'd3);
    bus.clr_status = 1'b1; tick(); bus.clr_status = 1'b0;
    check("flags_clr", {bus.err, bus.tear}, 32'd0);
    bus.eq_valid = 1'b1; tick(); bus.eq_valid = 1'b0;

    // Out-of-range write ignored; cpu_wr with commit lands in shadow only
    cpu_write(4'd5, 16'hDEAD);
    clear_log();
    bus.commit = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 4'd0; bus.cpu_data = 16'h5555;
    t = cyc; tick();
    bus.commit = 1'b0; bus.cpu_wr = 1'b0;
    wait_idle("oor_idle");
    check_load("oor", 0, t + 4, 16'h1000, 16'h2000, 16'h7FFF, 16'h4000);

    // Mid-load reset
    clear_log();
    bus.commit = 1'b1; t = cyc; tick(); bus.commit = 1'b0;
    repeat (3) tick();
    check("mid_in_wr", 32'(bus.eq_wr), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_outs", {bus.eq_wr, bus.eq_wr_rst, bus.done, bus.err, bus.tear}, 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_gain", {bus.eq_gain_msb, bus.eq_gain_lsb}, 32'd0);
    clear_log();
    repeat (10) tick();
    check("mid_no_wr", wr_cyc.size() + rst_cyc.size() + done_cyc.size(), 32'd0);

    // Banks were cleared by reset: a fresh load writes zeros
    bus.commit = 1'b1; t = cyc; tick(); bus.commit = 1'b0;
    wait_idle("zero_idle");
    check_load("zero", 0, t + 4, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
